// File: rtl/gf_dot_acc.sv
// gf_dot_acc: GF(2^8) dot-product accumulator (polynomial 0x11D).
//
// Reads len element pairs from two external operand memories (one pair per cycle, read data
// returns one cycle after rd_en) and produces the XOR-sum of their GF(2^8) products. Each pair
// goes through a registered gf_mul (2-cycle multiply), so the result appears len+4 cycles after
// the accepted start (1 cycle for len==0).
//
// Optional feature: define GF_DOT_SEED_EN to add the seed input; the accumulator then starts
// from seed instead of 0x00.
//
// gf_mul ports:
//   clk, rst_n        clock, async active-low reset
//   valid_i           input operands valid
//   a_i, b_i [7:0]    operands
//   p_o [7:0]         product (REG_IN + REG_OUT cycles after the operands)
//   done_o            valid_i delayed to line up with p_o
//
// gf_dot_acc ports:
//   clk, rst_n              clock, async active-low reset
//   start, len              request a dot product of len pairs (accepted only when idle)
//   seed [7:0]              accumulator start value (GF_DOT_SEED_EN only)
//   rd_en, rd_addr          operand read strobe and element index
//   rd_data_a, rd_data_b    operand data, valid one cycle after rd_en
//   busy                    high whenever not idle
//   result [7:0]            dot-product result, held until the next accepted start
//   done                    one-cycle pulse when result is updated

module gf_mul #(
  parameter bit REG_IN  = 1'b1,
  parameter bit REG_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o,
  output logic       done_o
);

  logic [7:0] a_s, b_s, p_c;
  logic       v_s;

  if (REG_IN) begin : g_reg_in
    logic [7:0] a_q, b_q;
    logic       v_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
        v_q <= 1'b0;
      end else begin
        a_q <= a_i;
        b_q <= b_i;
        v_q <= valid_i;
      end
    end
    assign a_s = a_q;
    assign b_s = b_q;
    assign v_s = v_q;
  end else begin : g_comb_in
    assign a_s = a_i;
    assign b_s = b_i;
    assign v_s = valid_i;
  end

  // Shift-and-add multiply, reducing a by x^8 = x^4+x^3+x^2+1 at every shift.
  always_comb begin
    logic [7:0] aa;
    p_c = '0;
    aa  = a_s;
    for (int i = 0; i < 8; i++) begin
      if (b_s[i]) p_c = p_c ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
    end
  end

  if (REG_OUT) begin : g_reg_out
    logic [7:0] p_q;
    logic       d_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q <= '0;
        d_q <= 1'b0;
      end else begin
        p_q <= p_c;
        d_q <= v_s;
      end
    end
    assign p_o    = p_q;
    assign done_o = d_q;
  end else begin : g_comb_out
    assign p_o    = p_c;
    assign done_o = v_s;
  end

endmodule

module gf_dot_acc #(
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
`ifdef GF_DOT_SEED_EN
  input  logic [7:0]            seed,
`endif
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data_a,
  input  logic [7:0]            rd_data_b,
  output logic                  busy,
  output logic [7:0]            result,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StFin} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] idx_q, idx_d;
  // [0]: operands on the read bus, [1]: in gf_mul input regs, [2]: product at gf_mul output
  logic [2:0]           vld_q, vld_d;
  logic [7:0]           acc_q, acc_d;
  logic [7:0]           result_q, result_d;
  logic [7:0]           prod;
  logic [7:0]           seed_val;
  logic                 mul_done_unused;

`ifdef GF_DOT_SEED_EN
  assign seed_val = seed;
`else
  assign seed_val = 8'h00;
`endif

  // The pipeline valid comes from vld_q; gf_mul's own done is left unconnected on purpose so
  // that reset of this block alone decides which products are accumulated.
  gf_mul #(
    .REG_IN  (1'b1),
    .REG_OUT (1'b1)
  ) u_gf_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (vld_q[0]),
    .a_i     (rd_data_a),
    .b_i     (rd_data_b),
    .p_o     (prod),
    .done_o  (mul_done_unused)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    result_d = result_q;
    vld_d    = {vld_q[1:0], (state_q == StRead)};

    if (vld_q[2]) acc_d = acc_q ^ prod;

    case (state_q)
      StIdle: begin
        if (start) begin
          len_d   = len;
          idx_d   = '0;
          acc_d   = seed_val;
          state_d = (len == '0) ? StFin : StRead;
        end
      end
      StRead: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == len_q - 1'b1) state_d = StDrain;
      end
      StDrain: begin
        // The product in stage 2 is folded in on this edge, so only stages 0/1 must be empty.
        if (vld_q[1:0] == 2'b00) state_d = StFin;
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Latch the final sum as FIN is entered so result only changes alongside done.
    if (state_d == StFin && state_q != StFin) result_d = acc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      len_q    <= '0;
      idx_q    <= '0;
      vld_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign rd_en   = (state_q == StRead);
  assign rd_addr = rd_en ? ADDR_WIDTH'(idx_q) : '0;
  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StFin);
  assign result  = result_q;

endmodule

// File: doc/gf_dot_acc.md
GF_DOT_ACC -- requirements
Module: gf_dot_acc

Interface
REQ-001 The block SHALL have parameter LEN_WIDTH, default 8: width of the vector-length input.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: width of the operand read addresses.
REQ-003 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port start, input, 1: request a dot product; accepted only in IDLE.
REQ-007 Port len, input, LEN_WIDTH: number of element pairs; sampled on the accepted start.
REQ-008 Port rd_en, output, 1: operand read strobe, one element pair per cycle.
REQ-009 Port rd_addr, output, ADDR_WIDTH: element index for both operand memories.
REQ-010 Port rd_data_a, input, 8: operand A; valid exactly one cycle after rd_en.
REQ-011 Port rd_data_b, input, 8: operand B; valid exactly one cycle after rd_en.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port result, output, 8: XOR-sum of the GF(2^8) products; held until the next accepted start.
REQ-014 Port done, output, 1: one-cycle pulse marking result valid.

Function
REQ-015 The block SHALL compute result = XOR over i=0..len-1 of a[i]*b[i] in GF(2^8) with polynomial x^8+x^4+x^3+x^2+1 (0x11D).
REQ-016 The block SHALL multiply using one gf_mul instance with REG_IN=1 and REG_OUT=1, giving a fixed 2-cycle multiply latency.
REQ-017 The FSM SHALL have exactly four states: IDLE, READ, DRAIN and FIN.
REQ-018 IDLE->READ SHALL occur on start with len!=0; IDLE->FIN SHALL occur on start with len==0.
REQ-019 In READ the block SHALL assert rd_en for len consecutive cycles with rd_addr 0,1,...,len-1, then go to DRAIN.
REQ-020 Product validity SHALL be tracked by a 3-stage resettable valid shift register inside this block; the done output of gf_mul SHALL NOT be used.
REQ-021 The accumulator SHALL XOR each valid product on the edge that ends the product's valid cycle.
REQ-022 DRAIN->FIN SHALL occur when the valid pipeline is empty; FIN SHALL last one cycle, pulse done, and return to IDLE.
REQ-023 Latency: with start accepted in cycle T, rd_en is high in cycles T+1..T+len and done is high in cycle T+len+4.
REQ-024 With len==0, done SHALL pulse in cycle T+1 and result SHALL be 0x00 (seed value under REQ-030).
REQ-025 start SHALL be ignored while busy is high; an in-flight operation SHALL be unaffected.
REQ-026 The accumulator SHALL be cleared on an accepted start, so result updates only in the cycle done is high.
REQ-027 rd_addr SHALL be zero-extended from the element index; len above 2^ADDR_WIDTH is outside the supported range and its behaviour is undefined.

Reset
REQ-028 On rst_n low the block SHALL immediately enter IDLE, clear the valid pipeline, drive rd_en=0, rd_addr=0, busy=0, done=0 and result=0x00, and abandon any operation in progress.
REQ-029 After rst_n deasserts, the first start SHALL behave exactly as from power-up; data still inside gf_mul SHALL never reach the accumulator.

Configuration
REQ-030 With macro GF_DOT_SEED_EN defined, the block SHALL add input port seed[7:0], load seed into the accumulator on the accepted start, and produce result = seed XOR sum.
REQ-031 Without GF_DOT_SEED_EN, the seed port SHALL NOT exist and the accumulator SHALL start at 0x00.

Verification
REQ-032 len=1, a={0x02}, b={0x80}, start in cycle T -> rd_en high in cycle T+1 only; done in cycle T+5; result=0x1D.
REQ-033 len=2, a={0x02,0x03}, b={0x80,0x03} -> rd_addr 0 then 1; done in cycle T+6; result=0x18.
REQ-034 len=0 -> no rd_en; done in cycle T+1; result=0x00.
REQ-035 len=4 with a second start pulsed in cycle T+2 -> second start ignored; exactly one done, in cycle T+8.
REQ-036 len=8 with rst_n pulsed low in cycle T+5, then len=1, a={0x03}, b={0x03} -> outputs zero during reset; only one done, result=0x05.
REQ-037 GF_DOT_SEED_EN defined, seed=0xFF, len=1, a={0x02}, b={0x80} -> result=0xE2.
